bus_arbiter_nm: RTL and testbench

//   N-master system-bus arbiter, parametrised successor of the two-master arbiter.

---
 rtl/bus_arbiter_nm.sv | 184 ++++++++++++++++++
 tb/tb_bus_arbiter_nm.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_nm.sv
// N-master system-bus arbiter: fixed-priority or round-robin winner selection,
// serial slave-address capture, one-hot grant held until trans_done or watchdog release.
module bus_arbiter_nm #(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned SLAVE_ADDR_W   = 2,
    parameter int unsigned RR_MODE        = 1,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    localparam int unsigned MW = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic [NUM_MASTERS-1:0]  m_request,
    input  logic [NUM_MASTERS-1:0]  m_slave_sel,
    input  logic                    trans_done,
    output logic [NUM_MASTERS-1:0]  m_grant,
    output logic [MW-1:0]           bus_grant,
    output logic [SLAVE_ADDR_W-1:0] slave_sel,
    output logic                    arbiter_busy,
    output logic                    bus_busy,
    output logic                    timeout
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned CW = $clog2(SLAVE_ADDR_W + 1);
    localparam logic [TW-1:0] WD_LAST  = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [MW-1:0] PTR_RST  = MW'(NUM_MASTERS - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SLAVE_ADDR_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_BUSY
    } state_e;

    state_e                  state_q, state_d;
    logic [NUM_MASTERS-1:0]  m_grant_q, m_grant_d;
    logic [MW-1:0]           bus_grant_q, bus_grant_d;
    logic [SLAVE_ADDR_W-1:0] slave_sel_q, slave_sel_d;
    logic                    arbiter_busy_q, arbiter_busy_d;
    logic                    bus_busy_q, bus_busy_d;
    logic                    timeout_q, timeout_d;
    logic [MW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [SLAVE_ADDR_W-1:0] addr_sr_q, addr_sr_d;
    logic [TW-1:0]           wd_cnt_q, wd_cnt_d;

    logic [MW-1:0]           search_base;
    logic [MW-1:0]           cand;
    logic [MW-1:0]           win;
    int unsigned             off_s;
    int unsigned             sum_s;

    // Search from the base upward with wrap; iterating offsets high-to-low lets
    // the smallest offset (highest priority) be the last assignment.
    always_comb begin
        search_base = '0;
        cand        = '0;
        win         = '0;
        off_s       = 0;
        sum_s       = 0;
        if (RR_MODE != 0) begin
            search_base = (rr_ptr_q == PTR_RST) ? '0 : rr_ptr_q + MW'(1);
        end
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            off_s = NUM_MASTERS - 1 - k;
            sum_s = 32'(search_base) + off_s;
            if (sum_s >= NUM_MASTERS) begin
                sum_s = sum_s - NUM_MASTERS;
            end
            cand = MW'(sum_s);
            if (m_request[cand]) begin
                win = cand;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        m_grant_d      = m_grant_q;
        bus_grant_d    = bus_grant_q;
        slave_sel_d    = slave_sel_q;
        arbiter_busy_d = arbiter_busy_q;
        bus_busy_d     = bus_busy_q;
        timeout_d      = 1'b0;
        rr_ptr_d       = rr_ptr_q;
        bit_cnt_d      = bit_cnt_q;
        addr_sr_d      = addr_sr_q;
        wd_cnt_d       = wd_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (|m_request) begin
                    m_grant_d      = '0;
                    m_grant_d[win] = 1'b1;
                    bus_grant_d    = win;
                    rr_ptr_d       = win;
                    addr_sr_d      = SLAVE_ADDR_W'(m_slave_sel[win]);
                    bit_cnt_d      = CW'(1);
                    if (SLAVE_ADDR_W == 1) begin
                        slave_sel_d = addr_sr_d;
                        bus_busy_d  = 1'b1;
                        wd_cnt_d    = '0;
                        state_d     = ST_BUSY;
                    end else begin
                        arbiter_busy_d = 1'b1;
                        state_d        = ST_ADDR;
                    end
                end
            end

            ST_ADDR: begin
                addr_sr_d = (addr_sr_q << 1) | SLAVE_ADDR_W'(m_slave_sel[bus_grant_q]);
                bit_cnt_d = bit_cnt_q + CW'(1);
                if (bit_cnt_d == CNT_LAST) begin
                    slave_sel_d    = addr_sr_d;
                    arbiter_busy_d = 1'b0;
                    bus_busy_d     = 1'b1;
                    wd_cnt_d       = '0;
                    state_d        = ST_BUSY;
                end
            end

            ST_BUSY: begin
                if (trans_done) begin
                    m_grant_d  = '0;
                    bus_busy_d = 1'b0;
                    state_d    = ST_IDLE;
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (wd_cnt_q == WD_LAST) begin
                        m_grant_d  = '0;
                        bus_busy_d = 1'b0;
                        timeout_d  = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        wd_cnt_d = wd_cnt_q + TW'(1);
                    end
                end
            end

            default: begin
                m_grant_d      = '0;
                arbiter_busy_d = 1'b0;
                bus_busy_d     = 1'b0;
                state_d        = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q        <= ST_IDLE;
            m_grant_q      <= '0;
            bus_grant_q    <= '0;
            slave_sel_q    <= '0;
            arbiter_busy_q <= 1'b0;
            bus_busy_q     <= 1'b0;
            timeout_q      <= 1'b0;
            rr_ptr_q       <= PTR_RST;
            bit_cnt_q      <= '0;
            addr_sr_q      <= '0;
            wd_cnt_q       <= '0;
        end else begin
            state_q        <= state_d;
            m_grant_q      <= m_grant_d;
            bus_grant_q    <= bus_grant_d;
            slave_sel_q    <= slave_sel_d;
            arbiter_busy_q <= arbiter_busy_d;
            bus_busy_q     <= bus_busy_d;
            timeout_q      <= timeout_d;
            rr_ptr_q       <= rr_ptr_d;
            bit_cnt_q      <= bit_cnt_d;
            addr_sr_q      <= addr_sr_d;
            wd_cnt_q       <= wd_cnt_d;
        end
    end

    assign m_grant      = m_grant_q;
    assign bus_grant    = bus_grant_q;
    assign slave_sel    = slave_sel_q;
    assign arbiter_busy = arbiter_busy_q;
    assign bus_busy     = bus_busy_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_bus_arbiter_nm.sv
// Scoreboard bench for bus_arbiter_nm: a round-robin instance checked through an
// event queue, plus a fixed-priority instance sharing the same inputs.
module tb_bus_arbiter_nm;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b0;
    logic [3:0] m_request = '0;
    logic [3:0] m_slave_sel = '0;
    logic       trans_done = 1'b0;

    logic [3:0] m_grant;
    logic [1:0] bus_grant;
    logic [1:0] slave_sel;
    logic       arbiter_busy, bus_busy, timeout;

    logic [3:0] fp_m_grant;
    logic [1:0] fp_bus_grant;
    logic [1:0] fp_slave_sel;
    logic       fp_arbiter_busy, fp_bus_busy, fp_timeout;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          is_to;
        int unsigned idx;
        logic [1:0]  addr;
    } exp_t;

    exp_t exp_q[$];
    logic prev_busy = 1'b0;
    logic [1:0] addr_tab [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10};

    bus_arbiter_nm #(
        .NUM_MASTERS(4), .SLAVE_ADDR_W(2), .RR_MODE(1), .TIMEOUT_CYCLES(16)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .m_request(m_request),
        .m_slave_sel(m_slave_sel), .trans_done(trans_done), .m_grant(m_grant),
        .bus_grant(bus_grant), .slave_sel(slave_sel), .arbiter_busy(arbiter_busy),
        .bus_busy(bus_busy), .timeout(timeout)
    );

    bus_arbiter_nm #(
        .NUM_MASTERS(4), .SLAVE_ADDR_W(2), .RR_MODE(0), .TIMEOUT_CYCLES(16)
    ) dut_fp (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .m_request(m_request),
        .m_slave_sel(m_slave_sel), .trans_done(trans_done), .m_grant(fp_m_grant),
        .bus_grant(fp_bus_grant), .slave_sel(fp_slave_sel), .arbiter_busy(fp_arbiter_busy),
        .bus_busy(fp_bus_busy), .timeout(fp_timeout)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expectation whenever the bus becomes owned or a watchdog release fires.
    always @(negedge sys_clk) begin
        exp_t e;
        if (bus_busy && !prev_busy) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_grant: got bus_grant=%0d with no expectation", bus_grant);
            end else begin
                e = exp_q.pop_front();
                chk("evt_kind_grant", 32'(e.is_to), 0);
                chk("sb_m_grant", 32'(m_grant), 32'(1) << e.idx);
                chk("sb_bus_grant", 32'(bus_grant), e.idx);
                chk("sb_slave_sel", 32'(slave_sel), 32'(e.addr));
                chk("sb_arb_busy_off", 32'(arbiter_busy), 0);
            end
        end
        if (timeout) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_timeout: got timeout=1 with no expectation");
            end else begin
                e = exp_q.pop_front();
                chk("evt_kind_timeout", 32'(e.is_to), 1);
                chk("to_m_grant", 32'(m_grant), 0);
                chk("to_bus_busy", 32'(bus_busy), 0);
                chk("to_bus_grant_hold", 32'(bus_grant), e.idx);
            end
        end
        prev_busy = bus_busy;
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic reset_check(input string name);
        chk(name, 32'({m_grant, bus_grant, slave_sel, arbiter_busy, bus_busy, timeout}), 0);
        chk({name, "_fp"}, 32'({fp_m_grant, fp_bus_grant, fp_slave_sel,
                               fp_arbiter_busy, fp_bus_busy, fp_timeout}), 0);
    endtask

    task automatic run_grant(input logic [3:0] req, input int unsigned w,
                             input logic [1:0] addr, input bit hold, input bit td_in_addr);
        m_request   = req;
        m_slave_sel = {4{addr[1]}};
        exp_q.push_back('{is_to: 1'b0, idx: w, addr: addr});
        tick();
        chk("grant_at_k", 32'(m_grant), 32'(1) << w);
        chk("arb_busy_in_addr", 32'(arbiter_busy), 1);
        chk("bus_busy_in_addr", 32'(bus_busy), 0);
        if (!hold) m_request = '0;
        m_slave_sel = {4{addr[0]}};
        trans_done  = td_in_addr;
        tick();
        trans_done = 1'b0;
        chk("bus_busy_k1", 32'(bus_busy), 1);
    endtask

    task automatic release_bus();
        trans_done = 1'b1;
        tick();
        trans_done = 1'b0;
        chk("rel_m_grant", 32'(m_grant), 0);
        chk("rel_bus_busy", 32'(bus_busy), 0);
        chk("rel_timeout", 32'(timeout), 0);
    endtask

    initial begin
        #12;
        reset_check("reset_state");
        @(negedge sys_clk);
        sys_rst = 1'b1;

        // 1: single request, address 1 then 0
        run_grant(4'b0001, 0, 2'b10, 1'b0, 1'b0);
        release_bus();

        // 2: all masters requesting; pointer restarts from reset
        sys_rst = 1'b0;
        #2;
        reset_check("reset_idle");
        sys_rst = 1'b1;
        for (int unsigned k = 0; k < 5; k++) begin
            run_grant(4'b1111, k % 4, addr_tab[k], 1'b1, 1'b0);
            chk("fp_m_grant", 32'(fp_m_grant), 1);
            chk("fp_bus_grant", 32'(fp_bus_grant), 0);
            release_bus();
        end
        m_request = '0;

        // 3: watchdog release, then trans_done on the final watchdog edge
        run_grant(4'b0100, 2, 2'b01, 1'b0, 1'b0);
        exp_q.push_back('{is_to: 1'b1, idx: 2, addr: 2'b01});
        repeat (15) tick();
        chk("busy_before_to", 32'(bus_busy), 1);
        chk("no_early_to", 32'(timeout), 0);
        tick();
        chk("to_pulse", 32'(timeout), 1);
        chk("to_idle_grant", 32'(m_grant), 0);
        tick();
        chk("to_one_cycle", 32'(timeout), 0);

        run_grant(4'b0100, 2, 2'b11, 1'b0, 1'b0);
        repeat (15) tick();
        trans_done = 1'b1;
        tick();
        trans_done = 1'b0;
        chk("td_wins_no_to", 32'(timeout), 0);
        chk("td_wins_grant", 32'(m_grant), 0);
        chk("td_wins_busy", 32'(bus_busy), 0);
        tick();
        chk("td_wins_no_to_late", 32'(timeout), 0);

        // 4: reset mid-ADDR and mid-BUSY
        m_request = 4'b0010;
        tick();
        chk("addr_grant_m1", 32'(m_grant), 32'b0010);
        chk("addr_state", 32'(arbiter_busy), 1);
        m_request = '0;
        #2 sys_rst = 1'b0;
        #1 reset_check("reset_mid_addr");
        sys_rst = 1'b1;
        run_grant(4'b1111, 0, 2'b01, 1'b0, 1'b0);
        tick();
        chk("busy_hold", 32'(bus_busy), 1);
        #2 sys_rst = 1'b0;
        #1 reset_check("reset_mid_busy");
        sys_rst = 1'b1;
        run_grant(4'b1111, 0, 2'b10, 1'b0, 1'b0);
        release_bus();

        // 5: trans_done ignored in ADDR; request during BUSY waits for release
        run_grant(4'b0010, 1, 2'b11, 1'b0, 1'b1);
        m_request = 4'b1000;
        repeat (3) tick();
        chk("m3_not_granted", 32'(m_grant), 32'b0010);
        chk("m3_busy_hold", 32'(bus_busy), 1);
        release_bus();
        run_grant(4'b1000, 3, 2'b01, 1'b0, 1'b0);
        release_bus();

        repeat (2) tick();
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule
